// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for CPU and debug/loader masters
// Optional starvation guard compiled in when ARB_STARVE_GUARD_EN is defined.
module mem_arbiter #(
   parameter int MEM_WORDS = 512,
   parameter int MAX_WAIT  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_wdata_i,
   output logic        cpu_gnt_o,
   output logic        cpu_rvalid_o,
   output logic [7:0]  cpu_rdata_o,

   input  logic        dbg_req_i,
   input  logic        dbg_we_i,
   input  logic [15:0] dbg_addr_i,
   input  logic [7:0]  dbg_wdata_i,
   output logic        dbg_gnt_o,
   output logic        dbg_rvalid_o,
   output logic [7:0]  dbg_rdata_o,

   input  logic        dbg_lock_i,
   output logic        locked_o,

   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [8:0]  mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i
);

   localparam logic [16:0] MEM_WORDS_L = 17'(MEM_WORDS);
   localparam logic [2:0]  MAX_WAIT_L  = 3'(MAX_WAIT);
   localparam logic        OWNER_CPU   = 1'b0;
   localparam logic        OWNER_DBG   = 1'b1;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t      state_q, state_d;

   // read-return bookkeeping captured at the grant
   logic        owner_q, owner_d;
   logic        rd_q, rd_d;
   logic        oor_q, oor_d;

   logic        cpu_gnt, dbg_gnt, any_gnt;
   logic        guard_fire;

   // selected master's request fields
   logic        win_dbg;
   logic        win_we;
   logic [15:0] win_addr;
   logic [7:0]  win_wdata;
   logic        win_in_range;
   logic        mem_access;

   logic [7:0]  ret_data;

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0]  wait_q, wait_d;

   // debug port takes the slot once it has waited MAX_WAIT cycles
   assign guard_fire = dbg_req_i && (wait_q == MAX_WAIT_L);

   // count consecutive ungranted debug-request cycles; forced to 0 while locked
   always_comb begin
      wait_d = 3'd0;
      if (state_q == ST_ARB && dbg_req_i && !dbg_gnt) begin
         if (wait_q == MAX_WAIT_L) begin
            wait_d = wait_q;
         end else begin
            wait_d = wait_q + 3'd1;
         end
      end
   end

   // wait counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q <= 3'd0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   // strict CPU priority: the debug port only wins when the CPU is idle
   assign guard_fire = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: enter LOCKED on a locked debug grant, leave when lock drops
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARB: begin
            if (dbg_gnt && dbg_lock_i) begin
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (!dbg_lock_i) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   // FSM outputs: grants; the cycle lock drops is already arbitrated normally
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst_i) begin
         if (state_q == ST_LOCKED && dbg_lock_i) begin
            dbg_gnt = dbg_req_i;
         end else begin
            cpu_gnt = cpu_req_i && !guard_fire;
            dbg_gnt = dbg_req_i && (!cpu_req_i || guard_fire);
         end
      end
   end

   assign any_gnt   = cpu_gnt || dbg_gnt;
   assign cpu_gnt_o = cpu_gnt;
   assign dbg_gnt_o = dbg_gnt;
   assign locked_o  = !rst_i && (state_q == ST_LOCKED);

   // select the winning master's request fields
   always_comb begin
      win_dbg   = 1'b0;
      win_we    = 1'b0;
      win_addr  = 16'h0000;
      win_wdata = 8'h00;
      if (dbg_gnt) begin
         win_dbg   = 1'b1;
         win_we    = dbg_we_i;
         win_addr  = dbg_addr_i;
         win_wdata = dbg_wdata_i;
      end else if (cpu_gnt) begin
         win_we    = cpu_we_i;
         win_addr  = cpu_addr_i;
         win_wdata = cpu_wdata_i;
      end
   end

   // out-of-range accesses are granted but never reach the memory
   assign win_in_range = ({1'b0, win_addr} < MEM_WORDS_L);
   assign mem_access   = any_gnt && win_in_range;

   // memory strobe and fields, all zero when no access is issued
   always_comb begin
      mem_en_o    = mem_access;
      mem_we_o    = mem_access && win_we;
      mem_addr_o  = 9'h000;
      mem_wdata_o = 8'h00;
      if (mem_access) begin
         mem_addr_o  = win_addr[8:0];
         mem_wdata_o = win_wdata;
      end
   end

   // read tag capture: owner holds until the next grant
   always_comb begin
      owner_d = owner_q;
      rd_d    = any_gnt && !win_we;
      oor_d   = any_gnt && !win_in_range;
      if (any_gnt) begin
         owner_d = win_dbg ? OWNER_DBG : OWNER_CPU;
      end
   end

   // read tag registers; reset discards any read granted just before
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= OWNER_CPU;
         rd_q    <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         owner_q <= owner_d;
         rd_q    <= rd_d;
         oor_q   <= oor_d;
      end
   end

   assign ret_data = oor_q ? 8'hFF : mem_rdata_i;

   // route returned data to its owner; the other port sees zero
   always_comb begin
      cpu_rvalid_o = !rst_i && rd_q && (owner_q == OWNER_CPU);
      dbg_rvalid_o = !rst_i && rd_q && (owner_q == OWNER_DBG);
      cpu_rdata_o  = cpu_rvalid_o ? ret_data : 8'h00;
      dbg_rdata_o  = dbg_rvalid_o ? ret_data : 8'h00;
   end

endmodule
